cla_pipe_adder: RTL
===================

// Module: cla_pipe_adder
// PURPOSE
//  Parametrised, pipelined carry-lookahead adder/subtractor; successor to the 4-bit
//  combinational CLA. WIDTH is split into GROUP-bit lookahead groups, one register stage
//  per group (carry ripples group-to-group through the pipe). Valid/ready on both sides;
//  one operation per cycle sustained. Sits between operand regs and the result bus.
// PARAMETERS
//  WIDTH   16  operand/sum width; must be a multiple of GROUP and >= GROUP
//  GROUP    4  bits per lookahead group (generate/propagate computed per bit, prefix in group)
//  NG      WIDTH/GROUP (localparam) number of groups = pipeline stages = latency
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operands/mode valid this cycle
//  in_ready   out  1      block accepts operands this cycle
//  A_in       in   WIDTH  operand A
//  B_in       in   WIDTH  operand B
//  C_1        in   1      carry-in (add mode only)
//  sub        in   1      1: A_in - B_in; 0: A_in + B_in + C_1
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  S          out  WIDTH  sum/difference
//  CO         out  1      carry-out (sub mode: 1 = no borrow)
//  OVF        out  1      signed (two's-complement) overflow
// BEHAVIOUR
//  - Accept when in_valid && in_ready; drain when out_valid && out_ready.
//  - Operand prep at accept: Beff = sub ? ~B_in : B_in; cin = sub ? 1 : C_1 (C_1 ignored in sub).
//  - Stage k (0..NG-1) computes group k: g=a&b, p=a^b, group carries by lookahead
//    c[i+1]=g[i]|p[i]&c[i] flattened within group; sum=p^c. Carry-out of group k and
//    already-computed sum bits [GROUP*(k+1)-1:0] pass to stage k+1 with untouched upper
//    operand bits and sign info; each stage has its own valid bit.
//  - Latency NG cycles accept->out_valid when unstalled; throughput 1/cycle.
//  - Stall: global. advance = !out_valid || out_ready. in_ready = advance. When advance=0
//    every stage holds (no bubbles collapsed); when 1, all stages shift, bubbles included.
//  - Combinational path in_ready<-out_ready permitted (one gate); no path from in_valid to out_*.
//  - S/CO/OVF are registered outputs of last stage; held stable while out_valid && !out_ready.
//  - CO = carry out of bit WIDTH-1. OVF = (A[W-1]==Beff[W-1]) && (S[W-1]!=A[W-1]).
//  - Wrap-around: sums are modulo 2^WIDTH; no saturation.
//  - Reset: all stage valids, out_valid, S, CO, OVF -> 0 on the clk edge where rst=1;
//    in-flight ops discarded. in_ready=1 in the first cycle after reset. rst overrides accept.
//  - Simultaneous accept and drain with full pipe: allowed, no loss, order preserved (FIFO order).
//  - NG==1: degenerates to single registered CLA stage, same handshake.
// TESTING (WIDTH=16, GROUP=4, NG=4)
//  1 A=0xFFFF B=0x0001 C_1=0 sub=0, out_ready=1 -> 4 cycles later S=0x0000 CO=1 OVF=0
//  2 A=0x7FFF B=0x0001 C_1=0 sub=0 -> S=0x8000 CO=0 OVF=1; A=0x1234 B=0x1111 C_1=1 -> S=0x2346
//  3 sub: A=0x0005 B=0x0007 C_1=1 -> S=0xFFFE CO=0 OVF=0; A=0x8000 B=0x0001 -> S=0x7FFF CO=1 OVF=1
//  4 stream 10 random ops back-to-back, out_ready=1 -> 10 results on consecutive cycles, in order,
//    matching reference model (A+B+C_1 / A-B mod 2^16)
//  5 stream 8 ops, out_ready low for 3 cycles mid-stream -> in_ready low same cycles, S held stable,
//    no op lost/duplicated, order preserved
//  6 rst asserted 1 cycle with 3 ops in flight -> out_valid=0, S=0 next cycle; no stale result
//    ever emerges; op accepted after reset appears 4 cycles later

Source files
------------

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// WIDTH is split into NG = WIDTH/GROUP lookahead groups; stage k resolves group k and
// hands its carry-out, the finished low sum bits and the untouched operands to stage k+1.
// One global advance signal stalls or shifts every stage together.
module cla_pipe_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic             C_1,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             OVF
);

    localparam int unsigned NG = WIDTH / GROUP;

    // Stage registers: index k holds the state after group k has been resolved.
    logic             v_q [NG];
    logic [WIDTH-1:0] a_q [NG];
    logic [WIDTH-1:0] b_q [NG];
    logic [WIDTH-1:0] s_q [NG];
    logic             c_q [NG];
    logic             ovf_q;

    // Stage inputs (prepared operands for stage 0, previous register otherwise).
    logic             src_v [NG];
    logic [WIDTH-1:0] src_a [NG];
    logic [WIDTH-1:0] src_b [NG];
    logic [WIDTH-1:0] src_s [NG];
    logic             src_c [NG];

    // Stage results.
    logic [WIDTH-1:0] nxt_s [NG];
    logic             nxt_c [NG];
    logic             nxt_ovf;

    logic             advance;

    // Per-group lookahead temporaries.
    logic [GROUP-1:0] gg;
    logic [GROUP-1:0] pp;
    logic [GROUP:0]   cc;
    logic             acc;
    logic             prop;

    // Global stall: the whole pipe moves only when the output slot is free or draining.
    always_comb begin
        advance   = !v_q[NG-1] || out_ready;
        in_ready  = advance;
        out_valid = v_q[NG-1];
        S         = s_q[NG-1];
        CO        = c_q[NG-1];
        OVF       = ovf_q;
    end

    // Route operands into each stage; subtraction becomes A + ~B + 1 at the entry.
    always_comb begin
        src_v[0] = in_valid;
        src_a[0] = A_in;
        src_b[0] = sub ? ~B_in : B_in;
        src_c[0] = sub ? 1'b1 : C_1;
        src_s[0] = '0;
        for (int k = 1; k < int'(NG); k++) begin
            src_v[k] = v_q[k-1];
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = s_q[k-1];
            src_c[k] = c_q[k-1];
        end
    end

    // Resolve one group per stage with flattened lookahead carries inside the group.
    always_comb begin
        gg   = '0;
        pp   = '0;
        cc   = '0;
        acc  = 1'b0;
        prop = 1'b0;
        for (int k = 0; k < int'(NG); k++) begin
            gg    = src_a[k][k*GROUP +: GROUP] & src_b[k][k*GROUP +: GROUP];
            pp    = src_a[k][k*GROUP +: GROUP] ^ src_b[k][k*GROUP +: GROUP];
            cc    = '0;
            cc[0] = src_c[k];
            // c[j] = g[j-1] | p[j-1]g[j-2] | ... | p[j-1..0]c[0], built as a sum of products.
            for (int j = 1; j <= int'(GROUP); j++) begin
                acc  = 1'b0;
                prop = 1'b1;
                for (int m = j - 1; m >= 0; m--) begin
                    acc  = acc | (prop & gg[m]);
                    prop = prop & pp[m];
                end
                cc[j] = acc | (prop & cc[0]);
            end
            nxt_s[k]                    = src_s[k];
            nxt_s[k][k*GROUP +: GROUP]  = pp ^ cc[GROUP-1:0];
            nxt_c[k]                    = cc[GROUP];
        end
        nxt_ovf = (src_a[NG-1][WIDTH-1] == src_b[NG-1][WIDTH-1])
                  && (nxt_s[NG-1][WIDTH-1] != src_a[NG-1][WIDTH-1]);
    end

    // Pipeline registers: reset discards everything, otherwise shift all stages on advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(NG); k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < int'(NG); k++) begin
                v_q[k] <= src_v[k];
                a_q[k] <= src_a[k];
                b_q[k] <= src_b[k];
                s_q[k] <= nxt_s[k];
                c_q[k] <= nxt_c[k];
            end
            ovf_q <= nxt_ovf;
        end
    end

endmodule
